// File: rtl/vproc_pkg.sv
// Shared types for the vector processor's scalar result path.
// xreg_result_t is the entry format of the x-register result queue.
package vproc_pkg;

    // Upper bound on XIF instruction ID width; narrower IDs are zero-extended.
    localparam int unsigned XREG_ID_MAX_W = 8;

    typedef struct packed {
        logic [XREG_ID_MAX_W-1:0] id;
        logic [4:0]               addr;
        logic [31:0]              data;
    } xreg_result_t;

endpackage

// File: rtl/vproc_xreg_result_queue_sva.svh
// Properties of vproc_xreg_result_queue; included inside the module body.
// Occupancy bounds, full-queue backpressure and head stability under stall.

    a_param_depth : assert property (@(posedge clk_i)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (XIF_ID_W <= XREG_ID_MAX_W));

    a_count_bound : assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        count_q <= FULL_CNT);

    a_full_no_ready : assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        (count_q == FULL_CNT) |-> (!pipe0_ready_o && !pipe1_ready_o));

    a_pipe0_wins : assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        (count_q == ALMOST_FULL_CNT && pipe0_valid_i) |-> !pipe1_ready_o);

    a_head_stable : assert property (@(posedge clk_i) disable iff (!async_rst_ni || !sync_rst_ni)
        (result_xreg_valid_o && !result_xreg_ready_i) |=>
            (result_xreg_valid_o && $stable(result_xreg_id_o) &&
             $stable(result_xreg_addr_o) && $stable(result_xreg_data_o)));

// File: rtl/vproc_xreg_result_queue.sv
// Two-input x-register result queue (ELEM + LSU) feeding the XIF result stage.
// Optional same-cycle bypass when the queue is empty: VPROC_XREG_QUEUE_BYPASS_EN.
module vproc_xreg_result_queue
    import vproc_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned DEPTH          = 4,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         async_rst_ni,
    input  logic                         sync_rst_ni,

    input  logic                         pipe0_valid_i,
    output logic                         pipe0_ready_o,
    input  logic [XIF_ID_W-1:0]          pipe0_id_i,
    input  logic [4:0]                   pipe0_addr_i,
    input  logic [31:0]                  pipe0_data_i,

    input  logic                         pipe1_valid_i,
    output logic                         pipe1_ready_o,
    input  logic [XIF_ID_W-1:0]          pipe1_id_i,
    input  logic [4:0]                   pipe1_addr_i,
    input  logic [31:0]                  pipe1_data_i,

    output logic                         result_xreg_valid_o,
    input  logic                         result_xreg_ready_i,
    output logic [XIF_ID_W-1:0]          result_xreg_id_o,
    output logic [4:0]                   result_xreg_addr_o,
    output logic [31:0]                  result_xreg_data_o,

    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT        = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALMOST_FULL_CNT = CNT_W'(DEPTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready depends only on registered count (plus pipe0_valid_i for
    // pipe1 priority), never on the pop, so freed slots appear one cycle later.

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    xreg_result_t     mem_q [DEPTH];
    xreg_result_t     mem_d [DEPTH];

    xreg_result_t     pipe0_entry, pipe1_entry, head;
    logic             push0, push1;
    logic             head_valid, bypass_pop, pop_mem;
    logic             wr0_en, wr1_en;
    logic [PTR_W-1:0] wr1_idx;
    logic             unused_head_id;

    assign pipe0_entry = '{id: XREG_ID_MAX_W'(pipe0_id_i), addr: pipe0_addr_i, data: pipe0_data_i};
    assign pipe1_entry = '{id: XREG_ID_MAX_W'(pipe1_id_i), addr: pipe1_addr_i, data: pipe1_data_i};

    // pipe0 owns the last free slot; pipe1 only takes it when pipe0 is idle.
    assign pipe0_ready_o = count_q < FULL_CNT;
    assign pipe1_ready_o = (count_q < ALMOST_FULL_CNT) ||
                           ((count_q == ALMOST_FULL_CNT) && !pipe0_valid_i);

    assign push0 = pipe0_valid_i & pipe0_ready_o;
    assign push1 = pipe1_valid_i & pipe1_ready_o;

    always_comb begin
        head_valid = (count_q != '0);
        head       = mem_q[rd_ptr_q];
        bypass_pop = 1'b0;
`ifdef VPROC_XREG_QUEUE_BYPASS_EN
        if ((count_q == '0) && (pipe0_valid_i ^ pipe1_valid_i)) begin
            head_valid = 1'b1;
            head       = pipe0_valid_i ? pipe0_entry : pipe1_entry;
            bypass_pop = result_xreg_ready_i;
        end
`endif
    end

    assign pop_mem = (count_q != '0) & result_xreg_ready_i;

    always_comb begin
        // An entry consumed through the bypass never touches storage.
        wr0_en  = push0 & ~bypass_pop;
        wr1_en  = push1 & ~bypass_pop;
        wr1_idx = wr_ptr_q + PTR_W'(wr0_en);

        mem_d = mem_q;
        if (wr0_en) begin
            mem_d[wr_ptr_q] = pipe0_entry;
        end
        if (wr1_en) begin
            mem_d[wr1_idx] = pipe1_entry;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en) + PTR_W'(wr1_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_mem);
        count_d  = count_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop_mem);

        if (!sync_rst_ni) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        result_xreg_id_o   = DONT_CARE_ZERO ? '0 : 'x;
        result_xreg_addr_o = DONT_CARE_ZERO ? '0 : 'x;
        result_xreg_data_o = DONT_CARE_ZERO ? '0 : 'x;
        if (head_valid) begin
            result_xreg_id_o   = head.id[XIF_ID_W-1:0];
            result_xreg_addr_o = head.addr;
            result_xreg_data_o = head.data;
        end
    end

    assign unused_head_id      = ^head.id;
    assign result_xreg_valid_o = head_valid;
    assign empty_o             = (count_q == '0);
    assign count_o             = count_q;

`ifdef VPROC_SVA
`include "vproc_xreg_result_queue_sva.svh"
`endif

endmodule

// File: tb/tb_vproc_xreg_result_queue.sv
// Directed self-checking bench for vproc_xreg_result_queue (DEPTH=4, XIF_ID_W=3).
// Expectations adapt when VPROC_XREG_QUEUE_BYPASS_EN is defined.
module tb_vproc_xreg_result_queue;

    localparam int unsigned ID_W  = 3;
    localparam int unsigned ENT_W = ID_W + 5 + 32;

    logic              clk_i = 1'b0;
    logic              async_rst_ni, sync_rst_ni;
    logic              pipe0_valid_i, pipe0_ready_o;
    logic [ID_W-1:0]   pipe0_id_i;
    logic [4:0]        pipe0_addr_i;
    logic [31:0]       pipe0_data_i;
    logic              pipe1_valid_i, pipe1_ready_o;
    logic [ID_W-1:0]   pipe1_id_i;
    logic [4:0]        pipe1_addr_i;
    logic [31:0]       pipe1_data_i;
    logic              result_xreg_valid_o, result_xreg_ready_i;
    logic [ID_W-1:0]   result_xreg_id_o;
    logic [4:0]        result_xreg_addr_o;
    logic [31:0]       result_xreg_data_o;
    logic              empty_o;
    logic [2:0]        count_o;

    logic [ENT_W-1:0]  exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;

    vproc_xreg_result_queue #(.XIF_ID_W(ID_W), .DEPTH(4), .DONT_CARE_ZERO(1'b1)) dut (
        .clk_i(clk_i), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
        .pipe0_valid_i(pipe0_valid_i), .pipe0_ready_o(pipe0_ready_o), .pipe0_id_i(pipe0_id_i),
        .pipe0_addr_i(pipe0_addr_i), .pipe0_data_i(pipe0_data_i),
        .pipe1_valid_i(pipe1_valid_i), .pipe1_ready_o(pipe1_ready_o), .pipe1_id_i(pipe1_id_i),
        .pipe1_addr_i(pipe1_addr_i), .pipe1_data_i(pipe1_data_i),
        .result_xreg_valid_o(result_xreg_valid_o), .result_xreg_ready_i(result_xreg_ready_i),
        .result_xreg_id_o(result_xreg_id_o), .result_xreg_addr_o(result_xreg_addr_o),
        .result_xreg_data_o(result_xreg_data_o), .empty_o(empty_o), .count_o(count_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_pipe0(input logic v, input logic [ID_W-1:0] id, input logic [4:0] addr,
                               input logic [31:0] data);
        pipe0_valid_i = v; pipe0_id_i = id; pipe0_addr_i = addr; pipe0_data_i = data;
    endtask

    task automatic drive_pipe1(input logic v, input logic [ID_W-1:0] id, input logic [4:0] addr,
                               input logic [31:0] data);
        pipe1_valid_i = v; pipe1_id_i = id; pipe1_addr_i = addr; pipe1_data_i = data;
    endtask

    task automatic push_exp(input logic [ID_W-1:0] id, input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({id, addr, data});
    endtask

    function automatic logic [31:0] rand_data();
        return 32'($urandom_range(0, 32'h7fff_ffff)) ^ 32'h8000_0000;
    endfunction

    // Scoreboard: the visible head must match the oldest expected entry.
    task automatic pop_check(input string tag);
        logic [ENT_W-1:0] e;
        check_val({tag, "_valid"}, 64'(result_xreg_valid_o), 64'd1);
        check_val({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val({tag, "_id"},   64'(result_xreg_id_o),   64'(e[39:37]));
            check_val({tag, "_addr"}, 64'(result_xreg_addr_o), 64'(e[36:32]));
            check_val({tag, "_data"}, 64'(result_xreg_data_o), 64'(e[31:0]));
        end
    endtask

    task automatic check_empty(input string tag);
        check_val({tag, "_empty"}, 64'(empty_o), 64'd1);
        check_val({tag, "_count"}, 64'(count_o), 64'd0);
        check_val({tag, "_valid"}, 64'(result_xreg_valid_o), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        async_rst_ni = 1'b0;
        sync_rst_ni  = 1'b1;
        drive_pipe0(1'b0, '0, '0, '0);
        drive_pipe1(1'b0, '0, '0, '0);
        result_xreg_ready_i = 1'b0;

        // Reset state
        @(negedge clk_i); #1;
        check_empty("rst");
        check_val("rst_rdy0", 64'(pipe0_ready_o), 64'd1);
        check_val("rst_rdy1", 64'(pipe1_ready_o), 64'd1);
        @(negedge clk_i);
        async_rst_ni = 1'b1;

        // Single push
        @(negedge clk_i);
        drive_pipe0(1'b1, 3'd2, 5'd5, 32'hDEAD_BEEF);
        result_xreg_ready_i = 1'b1;
        push_exp(3'd2, 5'd5, 32'hDEAD_BEEF);
        #1;
        check_val("t1_rdy0", 64'(pipe0_ready_o), 64'd1);
`ifdef VPROC_XREG_QUEUE_BYPASS_EN
        pop_check("t1_byp");
        @(negedge clk_i);
        drive_pipe0(1'b0, '0, '0, '0);
        #1;
        check_empty("t1_byp_after");
`else
        check_val("t1_lat_valid", 64'(result_xreg_valid_o), 64'd0);
        @(negedge clk_i);
        drive_pipe0(1'b0, '0, '0, '0);
        #1;
        check_val("t1_count", 64'(count_o), 64'd1);
        pop_check("t1_pop");
`endif
        @(negedge clk_i); #1;
        check_empty("t1_end");

        // Dual push, same cycle
        @(negedge clk_i);
        d = rand_data(); drive_pipe0(1'b1, 3'd1, 5'd7, d); push_exp(3'd1, 5'd7, d);
        d = rand_data(); drive_pipe1(1'b1, 3'd3, 5'd9, d); push_exp(3'd3, 5'd9, d);
        #1;
        check_val("t2_rdy0", 64'(pipe0_ready_o), 64'd1);
        check_val("t2_rdy1", 64'(pipe1_ready_o), 64'd1);
        check_val("t2_valid", 64'(result_xreg_valid_o), 64'd0);
        @(negedge clk_i);
        drive_pipe0(1'b0, '0, '0, '0); drive_pipe1(1'b0, '0, '0, '0);
        #1;
        check_val("t2_count", 64'(count_o), 64'd2);
        pop_check("t2_first");
        @(negedge clk_i); #1;
        pop_check("t2_second");
        @(negedge clk_i); #1;
        check_empty("t2_end");

        // Fill, backpressure, contention at DEPTH-1
        @(negedge clk_i);
        result_xreg_ready_i = 1'b0;
        d = rand_data(); drive_pipe0(1'b1, 3'd4, 5'd1, d); push_exp(3'd4, 5'd1, d);
        d = rand_data(); drive_pipe1(1'b1, 3'd5, 5'd2, d); push_exp(3'd5, 5'd2, d);
        @(negedge clk_i);
        d = rand_data(); drive_pipe0(1'b1, 3'd6, 5'd3, d); push_exp(3'd6, 5'd3, d);
        d = rand_data(); drive_pipe1(1'b1, 3'd7, 5'd4, d); push_exp(3'd7, 5'd4, d);
        #1;
        check_val("t3_rdy1_at2", 64'(pipe1_ready_o), 64'd1);
        @(negedge clk_i);
        drive_pipe0(1'b1, 3'd0, 5'd30, 32'h1111_1111);
        drive_pipe1(1'b1, 3'd0, 5'd31, 32'h2222_2222);
        #1;
        check_val("t3_full_count", 64'(count_o), 64'd4);
        check_val("t3_full_rdy0", 64'(pipe0_ready_o), 64'd0);
        check_val("t3_full_rdy1", 64'(pipe1_ready_o), 64'd0);
        @(negedge clk_i);
        result_xreg_ready_i = 1'b1;
        #1;
        check_val("t3_pop_rdy0", 64'(pipe0_ready_o), 64'd0);
        check_val("t3_pop_rdy1", 64'(pipe1_ready_o), 64'd0);
        pop_check("t3_pop4");
        @(negedge clk_i);
        result_xreg_ready_i = 1'b0;
        d = rand_data(); drive_pipe0(1'b1, 3'd0, 5'd10, d); push_exp(3'd0, 5'd10, d);
        drive_pipe1(1'b1, 3'd1, 5'd11, 32'h3333_3333);
        #1;
        check_val("t4_count3", 64'(count_o), 64'd3);
        check_val("t4_rdy0", 64'(pipe0_ready_o), 64'd1);
        check_val("t4_rdy1", 64'(pipe1_ready_o), 64'd0);
        @(negedge clk_i);
        drive_pipe0(1'b0, '0, '0, '0); drive_pipe1(1'b0, '0, '0, '0);
        result_xreg_ready_i = 1'b1;
        #1;
        check_val("t4_count4", 64'(count_o), 64'd4);
        check_val("t4_full_rdy0", 64'(pipe0_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk_i); #1;
            end
            pop_check("t4_drain");
        end
        @(negedge clk_i); #1;
        check_empty("t4_end");

        // Sequential push/pop pairs across pointer wrap
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk_i);
            result_xreg_ready_i = 1'b1;
            if (i < 10) begin
                d = rand_data();
                drive_pipe0(1'b1, i[2:0], 5'(i), d);
                push_exp(i[2:0], 5'(i), d);
            end else begin
                drive_pipe0(1'b0, '0, '0, '0);
            end
            #1;
`ifdef VPROC_XREG_QUEUE_BYPASS_EN
            if (i < 10) pop_check("t5_wrap");
`else
            if (i > 0) pop_check("t5_wrap");
`endif
        end
        @(negedge clk_i); #1;
        check_empty("t5_end");

        // Synchronous reset with three pending entries
        @(negedge clk_i);
        result_xreg_ready_i = 1'b0;
        drive_pipe0(1'b1, 3'd2, 5'd2, rand_data());
        drive_pipe1(1'b1, 3'd3, 5'd3, rand_data());
        @(negedge clk_i);
        drive_pipe0(1'b1, 3'd4, 5'd4, rand_data());
        drive_pipe1(1'b0, '0, '0, '0);
        @(negedge clk_i);
        drive_pipe0(1'b0, '0, '0, '0);
        #1;
        check_val("t6_count3", 64'(count_o), 64'd3);
        check_val("t6_rdy1_p0idle", 64'(pipe1_ready_o), 64'd1);
        sync_rst_ni = 1'b0;
        @(negedge clk_i);
        sync_rst_ni = 1'b1;
        #1;
        check_empty("t6_srst");
        check_val("t6_srst_rdy0", 64'(pipe0_ready_o), 64'd1);
        check_val("t6_srst_rdy1", 64'(pipe1_ready_o), 64'd1);

        // Asynchronous reset mid-cycle; stalled single push is stored either way
        @(negedge clk_i);
        drive_pipe0(1'b1, 3'd5, 5'd5, rand_data());
`ifdef VPROC_XREG_QUEUE_BYPASS_EN
        #1;
        check_val("t7_byp_stall_valid", 64'(result_xreg_valid_o), 64'd1);
`endif
        @(negedge clk_i);
        drive_pipe0(1'b0, '0, '0, '0);
        #1;
        check_val("t7_count1", 64'(count_o), 64'd1);
        #2;
        async_rst_ni = 1'b0;
        #1;
        check_empty("t7_arst");
        @(negedge clk_i);
        async_rst_ni = 1'b1;

        // Single pipe1 push into an empty queue with ready high
        @(negedge clk_i);
        result_xreg_ready_i = 1'b1;
        d = rand_data();
        drive_pipe1(1'b1, 3'd6, 5'd2, d);
        push_exp(3'd6, 5'd2, d);
        #1;
`ifdef VPROC_XREG_QUEUE_BYPASS_EN
        pop_check("t8_byp");
        check_val("t8_byp_count", 64'(count_o), 64'd0);
        @(negedge clk_i);
        drive_pipe1(1'b0, '0, '0, '0);
        #1;
        check_empty("t8_byp_after");
`else
        check_val("t8_lat_valid", 64'(result_xreg_valid_o), 64'd0);
        check_val("t8_rdy1", 64'(pipe1_ready_o), 64'd1);
        @(negedge clk_i);
        drive_pipe1(1'b0, '0, '0, '0);
        #1;
        check_val("t8_count", 64'(count_o), 64'd1);
        pop_check("t8_pop");
        @(negedge clk_i); #1;
        check_empty("t8_end");
`endif

        check_val("sb_drained", 64'(exp_q.size()), 64'd0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
